// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite initiator turning write/read commands into bus transfers
// Optional watchdog enabled by defining AXIL_TIMEOUT_EN.
module axil_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARST,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_write,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                aw_done;
    logic                w_done;
    logic                timeout;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign cmd_hs = i_cmd_valid && o_cmd_ready;
    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;

    // Only the error bit of each response code matters (SLVERR/DECERR).
    logic unused_resp_lsb;
    assign unused_resp_lsb = &{1'b0, BRESP[0], RRESP[0]};

`ifdef AXIL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             bus_state;
    logic             progress;

    assign bus_state = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                       (state == S_RD_REQ) || (state == S_RD_DATA);
    assign progress  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timeout   = bus_state && !progress && (tmo_cnt == CNT_LAST);

    // Counts cycles spent in the current bus state since the last handshake.
    always_ff @(posedge ACLK) begin
        if (ARST || !bus_state || progress || (state_nxt != state)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_hs) begin
                    state_nxt = i_cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (timeout) begin
                    state_nxt = S_RSP;
                end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (timeout || b_hs) begin
                    state_nxt = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (timeout) begin
                    state_nxt = S_RSP;
                end else if (ar_hs) begin
                    state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (timeout || r_hs) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Valids decode from state and registered done flags only, so no READY reaches a VALID.
    always_comb begin
        o_cmd_ready = 1'b0;
        AWVALID     = 1'b0;
        WVALID      = 1'b0;
        BREADY      = 1'b0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        o_rsp_valid = 1'b0;
        case (state)
            S_IDLE:    o_cmd_ready = !ARST;
            S_WR_REQ: begin
                AWVALID = !aw_done;
                WVALID  = !w_done;
            end
            S_WR_RESP: BREADY      = 1'b1;
            S_RD_REQ:  ARVALID     = 1'b1;
            S_RD_DATA: RREADY      = 1'b1;
            S_RSP:     o_rsp_valid = 1'b1;
            default:   o_cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_done <= 1'b1;
                end
                if (w_hs) begin
                    w_done <= 1'b1;
                end
            end
            if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (b_hs) begin
                rdata_q <= '0;
                err_q   <= BRESP[1];
            end else if (r_hs) begin
                rdata_q <= RDATA;
                err_q   <= RRESP[1];
            end
        end
    end

    assign AWADDR      = addr_q;
    assign ARADDR      = addr_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = '1;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed and randomized bench for axil_cmd_master with a behavioural AXI-Lite slave
// Timeout section switches on AXIL_TIMEOUT_EN.
module tb_axil_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    always #5 ACLK = ~ACLK;

    axil_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARST(ARST),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;

    // Slave configuration and observations.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, stab_err = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] smem [4];
    logic [31:0] exp_mem [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: decides READYs at the falling edge for the next rising edge.
    initial begin : slave
        int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        logic aw_fire = 0, w_fire = 0, ar_fire = 0, b_fire = 0, r_fire = 0;
        logic aw_got = 0, w_got = 0, aw_pend = 0, w_pend = 0, ar_pend = 0;
        logic [31:0] cap_aw = '0, cap_w = '0, cap_ar = '0, prev_aw = '0, prev_w = '0, prev_ar = '0;
        logic [3:0]  cap_s = '0;
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; BRESP = 0;
        RVALID = 0; RDATA = 0; RRESP = 0;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        forever begin
            @(negedge ACLK);
            if (b_fire) BVALID = 1'b0;
            if (r_fire) RVALID = 1'b0;
            if (aw_fire) begin aw_got = 1'b1; s_awaddr = cap_aw; end
            if (w_fire) begin w_got = 1'b1; s_wdata = cap_w; s_wstrb = cap_s; end
            if (aw_got && w_got) begin
                smem[s_awaddr[1:0]] = s_wdata;
                BVALID = 1'b1; BRESP = bresp_cfg;
                aw_got = 1'b0; w_got = 1'b0;
            end
            if (ar_fire) begin
                RVALID = 1'b1; RDATA = smem[cap_ar[1:0]]; RRESP = rresp_cfg;
            end
            if (AWVALID) begin
                aw_hi++;
                if (aw_pend && AWADDR !== prev_aw) stab_err++;
                AWREADY = (aw_cnt >= aw_delay); aw_cnt++;
            end else begin AWREADY = 1'b0; aw_cnt = 0; end
            if (WVALID) begin
                w_hi++;
                if (w_pend && WDATA !== prev_w) stab_err++;
                WREADY = (w_cnt >= w_delay); w_cnt++;
            end else begin WREADY = 1'b0; w_cnt = 0; end
            if (ARVALID) begin
                ar_hi++;
                if (ar_pend && ARADDR !== prev_ar) stab_err++;
                ARREADY = (ar_cnt >= ar_delay); ar_cnt++;
            end else begin ARREADY = 1'b0; ar_cnt = 0; end
            aw_fire = AWVALID && AWREADY; cap_aw = AWADDR;
            w_fire  = WVALID && WREADY;   cap_w = WDATA; cap_s = WSTRB;
            ar_fire = ARVALID && ARREADY; cap_ar = ARADDR;
            aw_pend = AWVALID && !AWREADY; prev_aw = AWADDR;
            w_pend  = WVALID && !WREADY;   prev_w = WDATA;
            ar_pend = ARVALID && !ARREADY; prev_ar = ARADDR;
            b_fire  = BVALID && BREADY;
            r_fire  = RVALID && RREADY;
        end
    end

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge ACLK);
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = data;
        n = 0;
        while (!o_cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        i_cmd_valid = 1'b0; i_cmd_write = 1'($urandom); i_cmd_addr = $urandom; i_cmd_wdata = $urandom;
        lat = 1;
        while (!o_rsp_valid && lat < 400) begin @(negedge ACLK); lat++; end
        check("rsp_seen", o_rsp_valid, 1'b1);
        rd = o_rsp_rdata; er = o_rsp_err;
        for (int i = 0; i < hold; i++) begin
            i_cmd_valid = 1'b1; i_cmd_write = 1'b0;
            @(negedge ACLK);
            check("hold_valid", o_rsp_valid, 1'b1);
            check("hold_rdata", o_rsp_rdata, rd);
            check("hold_err", o_rsp_err, er);
            check("hold_cmd_ready", o_cmd_ready, 1'b0);
            check("hold_arvalid", ARVALID, 1'b0);
        end
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge ACLK);
        i_rsp_ready = 1'b0;
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          lat;
        ARST = 1'b1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_wdata = 0;
        i_rsp_ready = 0;
        repeat (3) @(negedge ACLK);
        check("rst_cmd_ready", o_cmd_ready, 1'b0);
        check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, o_rsp_valid}, 6'b0);
        check("rst_rsp", {o_rsp_err, o_rsp_rdata}, 33'b0);
        check("rst_payload", {AWADDR, ARADDR, WDATA}, 96'b0);
        check("wstrb", WSTRB, 4'hF);
        ARST = 1'b0;
        @(negedge ACLK);
        check("idle_cmd_ready", o_cmd_ready, 1'b1);

        // Write 0x5 to r0 with AWREADY two cycles late and WREADY immediate.
        aw_delay = 2; w_delay = 0; aw_hi = 0; w_hi = 0;
        run_cmd(1'b1, 32'h0, 32'h5, 0, rd, er, lat);
        exp_mem[0] = 32'h5;
        check("aw_high_cycles", aw_hi, 3);
        check("w_high_cycles", w_hi, 1);
        check("wr0_rdata", rd, 32'h0);
        check("wr0_err", er, 1'b0);
        check("wr0_awaddr", s_awaddr, 32'h0);
        check("wr0_wdata", s_wdata, 32'h5);
        check("wr0_wstrb", s_wstrb, 4'hF);
        aw_delay = 0;

        // Load the remaining registers with zero-wait writes.
        for (int i = 1; i < 4; i++) begin
            exp_mem[i] = (i == 2) ? 32'h0000000C : $urandom;
            run_cmd(1'b1, 32'(i), exp_mem[i], 0, rd, er, lat);
            check("init_wr_latency", lat, 3);
            check("init_wr_err", er, 1'b0);
        end

        run_cmd(1'b0, 32'h2, 32'hDEAD_BEEF, 0, rd, er, lat);
        check("rd2_latency", lat, 3);
        check("rd2_rdata", rd, 32'h0000000C);
        check("rd2_err", er, 1'b0);

        bresp_cfg = 2'b10;
        exp_mem[3] = 32'h1;
        run_cmd(1'b1, 32'h3, 32'h1, 0, rd, er, lat);
        check("wr_slverr", er, 1'b1);
        check("wr_slverr_rdata", rd, 32'h0);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11;
        run_cmd(1'b0, 32'h1, 32'h0, 0, rd, er, lat);
        check("rd_decerr", er, 1'b1);
        rresp_cfg = 2'b00;

        // Response back-pressure for five cycles with a competing command.
        run_cmd(1'b0, 32'h0, 32'h0, 5, rd, er, lat);
        check("bp_rdata", rd, exp_mem[0]);

        // Reset while a read address phase is stalled.
        ar_delay = 1000;
        @(negedge ACLK);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h1;
        @(negedge ACLK);
        i_cmd_valid = 1'b0;
        check("mid_arvalid_up", ARVALID, 1'b1);
        @(negedge ACLK);
        ARST = 1'b1;
        @(negedge ACLK);
        check("mid_rst_arvalid", ARVALID, 1'b0);
        check("mid_rst_rsp_valid", o_rsp_valid, 1'b0);
        check("mid_rst_araddr", ARADDR, 32'h0);
        ARST = 1'b0; ar_delay = 0;
        @(negedge ACLK);
        check("mid_rst_cmd_ready", o_cmd_ready, 1'b1);
        run_cmd(1'b0, 32'h1, 32'h0, 0, rd, er, lat);
        check("post_rst_rdata", rd, exp_mem[1]);
        check("post_rst_latency", lat, 3);

        // Randomized traffic against the register-file model.
        for (int k = 0; k < 24; k++) begin
            logic        wr;
            logic [1:0]  a;
            logic [31:0] d;
            logic [1:0]  resp;
            wr = 1'($urandom); a = 2'($urandom); d = $urandom; resp = 2'($urandom);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            if (wr) bresp_cfg = resp; else rresp_cfg = resp;
            run_cmd(wr, {30'b0, a}, d, $urandom_range(0, 2), rd, er, lat);
            if (wr) begin
                exp_mem[a] = d;
                check("rnd_wr_rdata", rd, 32'h0);
                check("rnd_wr_addr", s_awaddr, {30'b0, a});
            end else begin
                check("rnd_rd_rdata", rd, exp_mem[a]);
            end
            check("rnd_err", er, resp[1]);
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0; bresp_cfg = 0; rresp_cfg = 0;

`ifdef AXIL_TIMEOUT_EN
        ar_delay = 100000; ar_hi = 0;
        run_cmd(1'b0, 32'h2, 32'h0, 0, rd, er, lat);
        check("tmo_ar_high", ar_hi, 16);
        check("tmo_err", er, 1'b1);
        check("tmo_rdata", rd, 32'h0);
        ar_delay = 0;
`else
        ar_delay = 100000;
        @(negedge ACLK);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h2;
        @(negedge ACLK);
        i_cmd_valid = 1'b0;
        repeat (100) @(negedge ACLK);
        check("nontmo_arvalid", ARVALID, 1'b1);
        check("nontmo_rsp_valid", o_rsp_valid, 1'b0);
        ar_delay = 0;
        lat = 0;
        while (!o_rsp_valid && lat < 50) begin @(negedge ACLK); lat++; end
        check("nontmo_rsp", o_rsp_valid, 1'b1);
        check("nontmo_rdata", o_rsp_rdata, exp_mem[2]);
        i_rsp_ready = 1'b1;
        @(negedge ACLK);
        i_rsp_ready = 1'b0;
`endif

        check("axi_stability", stab_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
Single-outstanding AXI4-Lite initiator that turns simple write/read commands into bus transactions toward the adder register-file slave (r0, r1, r2/result, ctrl at word addresses 0..3). It is used by the system controller and by bench sequencers to load operands, set the ctrl start bit and poll the result. It returns one response per command: read data plus an error flag.

Parameters:
ADDR_W, 32, width of command address and AWADDR/ARADDR
DATA_W, 32, width of command write data, WDATA, RDATA and response data
TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when AXIL_TIMEOUT_EN is defined; must be >= 2

Ports:
ACLK  in  1  clock
ARST  in  1  reset, synchronous, active-high
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid && ready
i_cmd_write  in  1  1=write, 0=read
i_cmd_addr  in  ADDR_W  target address
i_cmd_wdata  in  DATA_W  write data, ignored for reads
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed when valid && ready
o_rsp_rdata  out  DATA_W  read data; 0 for writes
o_rsp_err  out  1  1 when xRESP != OKAY, or on timeout
AWADDR  out  ADDR_W; AWVALID  out  1; AWREADY  in  1
WDATA  out  DATA_W; WSTRB  out  DATA_W/8; WVALID  out  1; WREADY  in  1
BRESP  in  2; BVALID  in  1; BREADY  out  1
ARADDR  out  ADDR_W; ARVALID  out  1; ARREADY  in  1
RDATA  in  DATA_W; RRESP  in  2; RVALID  in  1; RREADY  out  1

Behaviour:
- Reset (ARST high at a rising edge): state goes to IDLE. All VALID/READY outputs, o_rsp_valid, o_rsp_err and o_rsp_rdata go to 0. AWADDR, ARADDR and WDATA go to 0. Applies mid-transaction: an in-flight transfer is dropped at that edge.
- WSTRB is tied to all-ones.
- States and transitions:
  - IDLE: o_cmd_ready=1. Command handshake latches addr/wdata. Write -> WR_REQ; read -> RD_REQ.
  - WR_REQ: AWVALID and WVALID rise in the cycle after acceptance. Each drops independently the cycle after its own handshake. Both may complete in the same cycle, in either order. When both are done -> WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, capture o_rsp_err=BRESP[1] and o_rsp_rdata=0 -> RSP.
  - RD_REQ: ARVALID=1 until ARREADY -> RD_DATA.
  - RD_DATA: RREADY=1. On RVALID, capture o_rsp_rdata=RDATA and o_rsp_err=RRESP[1] -> RSP.
  - RSP: o_rsp_valid=1. Data and err are held stable until i_rsp_ready; then -> IDLE.
- o_cmd_ready is 0 in every state except IDLE. The earliest next command is accepted the cycle after the response handshake.
- AXI rules: once asserted, a VALID stays high and its payload stays stable until READY. No combinational path from any *READY input to any *VALID output. BREADY/RREADY are asserted only in WR_RESP/RD_DATA.
- Latency with zero-wait slave:
  - Write: cmd accept at cycle N, AW/W handshake at N+1, B at N+2, o_rsp_valid at N+3.
  - Read: cmd accept at N, AR at N+1, R at N+2, o_rsp_valid at N+3.
- BVALID/RVALID arriving before their state is reached are ignored; the slave must hold them.
- Input changes on i_cmd_* while not in IDLE have no effect.

Optional Feature:
AXIL_TIMEOUT_EN.
- Defined: a cycle counter runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA. It clears on entry to each of these states and on every AW, W, B, AR or R handshake. When the counter reaches TIMEOUT_CYCLES, all bus VALID/READY outputs drop at the next edge. The block then moves to RSP with o_rsp_err=1 and o_rsp_rdata=0. This is a fault-recovery path; the AXI stability rule is intentionally violated only here.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Write addr 0x0, data 0x5 with AWREADY delayed 2 cycles and WREADY immediate, BRESP=00 -> WVALID drops after 1 cycle, AWVALID held 3 cycles with stable AWADDR=0, then o_rsp_valid with err=0, rdata=0.
- Read addr 0x2, slave returns RDATA=0x0000000C, RRESP=00, zero-wait -> o_rsp_valid 3 cycles after cmd accept, rdata=0xC, err=0.
- Write addr 0x3 with BRESP=2'b10 -> o_rsp_err=1. Read with RRESP=2'b11 -> o_rsp_err=1.
- i_rsp_ready held low 5 cycles after a read -> o_rsp_valid, rdata and err stable throughout; o_cmd_ready=0 and no new ARVALID despite i_cmd_valid=1.
- ARST asserted one cycle after ARVALID rises (ARREADY low) -> at that edge ARVALID=0, o_rsp_valid=0, o_cmd_ready=1 after reset releases; a new read then completes normally.
- AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, ARREADY never asserted -> ARVALID drops after 16 cycles, o_rsp_valid=1, err=1, rdata=0. Without the macro, ARVALID stays high after 100 cycles.
